// File: rtl/ov7670_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ov7670_pkg
// Brief   : Shared types, bar colours and frame-geometry helpers for the
//           synthetic OV7670 stream generator.
// Rev     : 1.0 - initial release
// ============================================================================
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_ADDR  = 2'd3
  } pattern_t;

  // Element [0] is the leftmost bar (white), element [7] the rightmost (black).
  localparam logic [7:0][15:0] c_bar_colors = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  function automatic int line_clks(input int screen_x, input int hblank);
    return 2 * screen_x + hblank;
  endfunction

  function automatic int frame_clks(input int screen_x, input int screen_y,
                                    input int hblank, input int vsync_lines,
                                    input int vbp_lines, input int vfp_lines);
    return (vsync_lines + vbp_lines + screen_y + vfp_lines) * line_clks(screen_x, hblank);
  endfunction

  localparam int c_line_clks_default  = line_clks(160, 144);
  localparam int c_frame_clks_default = frame_clks(160, 120, 144, 3, 17, 10);

endpackage
`default_nettype wire

// File: rtl/ov7670_stream_gen_pattern_px.sv
`default_nettype none
// ============================================================================
// Module  : ov7670_pattern_px
// Brief   : Combinational RGB565 pixel generator for the four test patterns.
// Rev     : 1.0 - initial release
// ============================================================================
module ov7670_pattern_px
  import ov7670_pkg::*;
#(
  parameter int CAM_SCREEN_X = 160
) (
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  pattern_t    i_pattern,
  input  logic [15:0] i_color,
  output logic [15:0] o_pixel
);

  // Narrow screens still get one-pixel bars instead of a divide by zero.
  localparam int c_bar_px = (CAM_SCREEN_X / 8 > 0) ? CAM_SCREEN_X / 8 : 1;

  logic [15:0] w_bar_idx;
  logic [2:0]  w_bar;

  always_comb begin
    w_bar_idx = i_x / 16'(c_bar_px);
    w_bar     = (w_bar_idx > 16'd7) ? 3'd7 : w_bar_idx[2:0];
    o_pixel   = 16'h0000;
    case (i_pattern)
      PAT_BARS:  o_pixel = c_bar_colors[w_bar];
      PAT_GRAD:  o_pixel = {i_x[4:0], i_y[5:0], i_x[4:0]};
      PAT_SOLID: o_pixel = i_color;
      PAT_ADDR:  o_pixel = i_y * 16'(CAM_SCREEN_X) + i_x;
      default:   o_pixel = 16'h0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ov7670_stream_gen.sv
`default_nettype none
// ============================================================================
// Module  : ov7670_stream_gen
// Brief   : Synthetic OV7670 RGB565 byte-stream source (vsync/href/px_data).
//           OV7670_STREAM_GEN_CONTINUOUS_EN: stream frames back to back.
// Rev     : 1.0 - initial release
// ============================================================================
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int HBLANK       = 144,
  parameter int VSYNC_LINES  = 3,
  parameter int VBP_LINES    = 17,
  parameter int VFP_LINES    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inicio,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid_color,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  px_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int c_line_clks = line_clks(CAM_SCREEN_X, HBLANK);
  localparam int c_col_w     = $clog2(c_line_clks);
  localparam int c_max_a     = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int c_max_b     = (CAM_SCREEN_Y > VFP_LINES) ? CAM_SCREEN_Y : VFP_LINES;
  localparam int c_max_lines = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int c_line_w    = (c_max_lines > 1) ? $clog2(c_max_lines) : 1;

  localparam logic [c_col_w-1:0]  c_col_last    = c_col_w'(c_line_clks - 1);
  localparam logic [c_col_w-1:0]  c_active_end  = c_col_w'(2 * CAM_SCREEN_X);
  localparam logic [c_line_w-1:0] c_vsync_last  = c_line_w'(VSYNC_LINES - 1);
  localparam logic [c_line_w-1:0] c_vbp_last    = c_line_w'(VBP_LINES - 1);
  localparam logic [c_line_w-1:0] c_active_last = c_line_w'(CAM_SCREEN_Y - 1);
  localparam logic [c_line_w-1:0] c_vfp_last    = c_line_w'(VFP_LINES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [c_col_w-1:0]  r_col;
  logic [c_line_w-1:0] r_line;
  logic [c_line_w-1:0] w_line_last;
  logic                w_line_end;
  logic                w_phase_end;
  logic                w_latch;
  logic                w_href;
  pattern_t            r_pattern;
  logic [15:0]         r_color;
  logic [15:0]         w_x;
  logic [15:0]         w_y;
  logic [15:0]         w_pixel;
  logic                r_fd_arm;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_line_last  = c_vsync_last;
    case (r_state)
      ST_VBP:    w_line_last = c_vbp_last;
      ST_ACTIVE: w_line_last = c_active_last;
      ST_VFP:    w_line_last = c_vfp_last;
      default:   w_line_last = c_vsync_last;
    endcase
    w_line_end  = (r_col == c_col_last);
    w_phase_end = w_line_end && (r_line == w_line_last);

    case (r_state)
      ST_IDLE:   if (inicio)      w_state_next = ST_VSYNC;
      ST_VSYNC:  if (w_phase_end) w_state_next = ST_VBP;
      ST_VBP:    if (w_phase_end) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_phase_end) w_state_next = ST_VFP;
`ifdef OV7670_STREAM_GEN_CONTINUOUS_EN
      ST_VFP:    if (w_phase_end) w_state_next = ST_VSYNC;
`else
      ST_VFP:    if (w_phase_end) w_state_next = ST_IDLE;
`endif
      default:   w_state_next = ST_IDLE;
    endcase

    w_latch = (r_state == ST_IDLE) && inicio;
`ifdef OV7670_STREAM_GEN_CONTINUOUS_EN
    w_latch = w_latch || ((r_state == ST_VFP) && w_phase_end);
`endif

    w_href = (r_state == ST_ACTIVE) && (r_col < c_active_end);
    w_x    = 16'(r_col >> 1);
    w_y    = 16'(r_line);
  end

  // Counters idle at zero so every frame starts from column 0, line 0.
  always_ff @(posedge clk) begin
    if (rst || r_state == ST_IDLE) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (w_line_end) begin
      r_col  <= '0;
      r_line <= w_phase_end ? '0 : r_line + c_line_w'(1);
    end else begin
      r_col  <= r_col + c_col_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= PAT_BARS;
      r_color   <= 16'h0000;
    end else if (w_latch) begin
      r_pattern <= pattern_t'(pattern);
      r_color   <= solid_color;
    end
  end

  ov7670_pattern_px #(
    .CAM_SCREEN_X(CAM_SCREEN_X)
  ) u_pattern_px (
    .i_x       (w_x),
    .i_y       (w_y),
    .i_pattern (r_pattern),
    .i_color   (r_color),
    .o_pixel   (w_pixel)
  );

  // Outputs are a registered decode of the current state, one clock behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync      <= 1'b0;
      href       <= 1'b0;
      px_data    <= 8'h00;
      busy       <= 1'b0;
      r_fd_arm   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vsync      <= (r_state == ST_VSYNC);
      href       <= w_href;
      px_data    <= w_href ? (r_col[0] ? w_pixel[7:0] : w_pixel[15:8]) : 8'h00;
      busy       <= (r_state != ST_IDLE);
      r_fd_arm   <= (r_state == ST_VFP) && w_phase_end;
      frame_done <= r_fd_arm;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_stream_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_ov7670_stream_gen
// Brief   : Directed self-checking bench for ov7670_stream_gen on a reduced
//           32x12 geometry (line = 72 clocks, frame = 17 lines = 1224 clocks).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_ov7670_stream_gen;

  logic        clk;
  logic        rst;
  logic        inicio;
  logic [1:0]  pattern;
  logic [15:0] solid_color;
  logic        vsync;
  logic        href;
  logic [7:0]  px_data;
  logic        busy;
  logic        frame_done;

  int n_chk = 0;
  int n_err = 0;

  int cyc = 0;
  int vs_rise, vs_fall, vs_rise2, href_first, fd_first, fd_second;
  int fd_cnt, href_high, href_rises, bad_px, busy_low;
  logic p_vs, p_href;
  logic [7:0] q[$];

  ov7670_stream_gen #(
    .CAM_SCREEN_X(32),
    .CAM_SCREEN_Y(12),
    .HBLANK      (8),
    .VSYNC_LINES (2),
    .VBP_LINES   (2),
    .VFP_LINES   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inicio     (inicio),
    .pattern    (pattern),
    .solid_color(solid_color),
    .vsync      (vsync),
    .href       (href),
    .px_data    (px_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    vs_rise = -1; vs_fall = -1; vs_rise2 = -1; href_first = -1;
    fd_first = -1; fd_second = -1; fd_cnt = 0; href_high = 0;
    href_rises = 0; bad_px = 0; busy_low = 0;
    q.delete();
  endtask

  // Observation on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cyc++;
    if (vsync && !p_vs) begin
      if (vs_rise < 0) vs_rise = cyc;
      else if (vs_rise2 < 0) vs_rise2 = cyc;
    end
    if (!vsync && p_vs && vs_fall < 0) vs_fall = cyc;
    if (href) begin
      href_high++;
      q.push_back(px_data);
      if (!p_href) href_rises++;
      if (href_first < 0) href_first = cyc;
    end else if (px_data !== 8'h00) begin
      bad_px++;
    end
    if (frame_done) begin
      fd_cnt++;
      if (fd_first < 0) fd_first = cyc;
      else if (fd_second < 0) fd_second = cyc;
    end
    if (vs_rise >= 0 && !busy) busy_low++;
    p_vs   = vsync;
    p_href = href;
  end

  function automatic logic [15:0] px_at(input int x, input int y);
    int i;
    i = 2 * (y * 32 + x);
    if (i + 1 < q.size()) return {q[i], q[i+1]};
    return 16'hxxxx;
  endfunction

  task automatic wait_fd(input int n, input int budget);
    int k;
    k = 0;
    while (fd_cnt < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (fd_cnt < n) check("fd_timeout", fd_cnt, n);
  endtask

  task automatic run_frame(input logic [1:0] pat, input logic [15:0] col);
    @(posedge clk); #1;
    mon_clear();
    pattern = pat; solid_color = col; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    check("pre_vsync", {vsync, busy}, 2'b00);
    pattern = ~pat; solid_color = ~col;
    @(posedge clk); #1;
    check("start", {vsync, busy}, 2'b11);
    wait_fd(1, 1400);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic check_timing(input string tag);
    check({tag, "_vs_len"},     vs_fall - vs_rise,    144);
    check({tag, "_href_first"}, href_first - vs_rise, 288);
    check({tag, "_fd_time"},    fd_first - vs_rise,   1224);
    check({tag, "_fd_cnt"},     fd_cnt,               1);
    check({tag, "_href_clks"},  href_high,            768);
    check({tag, "_href_lines"}, href_rises,           12);
    check({tag, "_blank_px"},   bad_px,               0);
  endtask

  logic [15:0] bar_exp [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  initial begin
    int k;
    p_vs = 1'b0; p_href = 1'b0;
    mon_clear();
    rst = 1'b1; inicio = 1'b0; pattern = 2'd0; solid_color = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {vsync, href, busy, frame_done, px_data}, 12'h000);
    rst = 1'b0;

    run_frame(2'd3, 16'h0000);
    check_timing("addr");
    check("addr_p00",  px_at(0, 0),   16'h0000);
    check("addr_p10",  px_at(1, 0),   16'h0001);
    check("addr_l1",   px_at(0, 1),   16'h0020);
    check("addr_p72",  px_at(7, 2),   16'h0047);
    check("addr_p317", px_at(31, 7),  16'h00FF);
    check("addr_p08",  px_at(0, 8),   16'h0100);
    check("addr_last", px_at(31, 11), 16'h017F);

    run_frame(2'd0, 16'h0000);
    check("bars_len", q.size(), 768);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("bar%0d_lo", b), px_at(4 * b, 5),     bar_exp[b]);
      check($sformatf("bar%0d_hi", b), px_at(4 * b + 3, 5), bar_exp[b]);
    end

    run_frame(2'd1, 16'h0000);
    check("grad_p00", px_at(0, 0),   16'h0000);
    check("grad_p53", px_at(5, 3),   16'h2865);
    check("grad_end", px_at(31, 11), 16'hF97F);

    run_frame(2'd2, 16'hABCD);
    check("solid_first", px_at(0, 0),   16'hABCD);
    check("solid_mid",   px_at(8, 6),   16'hABCD);
    check("solid_last",  px_at(31, 11), 16'hABCD);

    // Reset in the middle of an active line.
    @(posedge clk); #1;
    mon_clear();
    pattern = 2'd3; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    k = 0;
    while (!href && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check("rst_reach_href", href, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid", {vsync, href, busy, frame_done, px_data}, 12'h000);
    rst = 1'b0;
    repeat (1300) @(posedge clk);
    #1;
    check("rst_no_fd", fd_cnt, 0);

    run_frame(2'd3, 16'h0000);
    check_timing("post_rst");
    check("post_rst_l1",   px_at(0, 1),   16'h0020);
    check("post_rst_last", px_at(31, 11), 16'h017F);

`ifdef OV7670_STREAM_GEN_CONTINUOUS_EN
    @(posedge clk); #1;
    mon_clear();
    pattern = 2'd3; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0; pattern = 2'd2; solid_color = 16'h5A5A;
    wait_fd(2, 2600);
    check("cont_first",      fd_first - vs_rise,   1224);
    check("cont_period",     fd_second - fd_first, 1224);
    check("cont_vs_restart", vs_rise2 - fd_first,  0);
    check("cont_busy_gap",   busy_low,             0);
    check("cont_fd_cnt",     fd_cnt,               2);
    check("cont_bytes",      q.size(),             1536);
    check("cont_f1_last",    px_at(31, 11),        16'h017F);
    check("cont_f2_first",   px_at(0, 12),         16'h5A5A);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
`else
    // inicio held high restarts on the cycle after frame_done.
    @(posedge clk); #1;
    mon_clear();
    pattern = 2'd2; solid_color = 16'h1357; inicio = 1'b1;
    wait_fd(1, 1400);
    repeat (3) @(posedge clk);
    #1;
    check("held_restart",  vs_rise2 - fd_first, 1);
    check("held_busy_gap", busy_low,            1);
    check("held_px",       px_at(3, 4),         16'h1357);
    inicio = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
